// File: rtl/rd_pkg.sv
// Shared encodings for the receive running-disparity path: RD states, symbol classes
// and the ones-count thresholds that separate them.
package rd_pkg;

  typedef enum logic [1:0] {
    RD_UNK = 2'b00,
    RD_NEG = 2'b01,
    RD_POS = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    NEUTRAL = 2'b00,
    POS     = 2'b01,
    NEG     = 2'b10,
    INVALID = 2'b11
  } sym_class_e;

  localparam logic [3:0] ONES_NEG     = 4'd4;
  localparam logic [3:0] ONES_NEUTRAL = 4'd5;
  localparam logic [3:0] ONES_POS     = 4'd6;

endpackage

// File: rtl/rd_sym_class.sv
// Combinational 10b symbol classifier: popcount mapped to NEUTRAL/POS/NEG/INVALID.
module rd_sym_class
  import rd_pkg::*;
(
  input  logic [9:0]  i_sym,
  output sym_class_e  o_class
);

  logic [3:0] w_ones;

  always_comb begin
    w_ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      w_ones = w_ones + 4'(i_sym[i]);
    end
  end

  always_comb begin
    o_class = INVALID;
    unique case (w_ones)
      ONES_NEUTRAL: o_class = NEUTRAL;
      ONES_POS:     o_class = POS;
      ONES_NEG:     o_class = NEG;
      default:      o_class = INVALID;
    endcase
  end

endmodule

// File: rtl/rx_rd_checker.sv
// Receive-side running-disparity tracker with lock status and error flags.
// Defining RD_ERR_CNT_EN adds err_cnt_clr/err_cnt and a saturating error counter.
module rx_rd_checker
  import rd_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 Bit_Rate_10,
  input  logic                 Rst,
  input  logic                 enable,
  input  logic [9:0]           Data_10,
`ifdef RD_ERR_CNT_EN
  input  logic                 err_cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [9:0]           Data_10_out,
  output logic                 valid_out,
  output logic                 RD_out,
  output logic                 disp_err,
  output logic                 code_err,
  output logic                 rd_locked
);

  if (LOCK_CNT < 1 || LOCK_CNT > 15 || ERR_CNT_W < 1) begin : g_param_chk
    $error("rx_rd_checker: LOCK_CNT must be 1..15 and ERR_CNT_W at least 1");
  end

  localparam logic [3:0] LockMax = 4'(LOCK_CNT);

  sym_class_e w_class;
  rd_state_e  r_state, w_state_nxt;
  logic [3:0] r_lock_cnt, w_lock_nxt;
  logic       w_disp, w_code;

  rd_sym_class u_class (
    .i_sym   (Data_10),
    .o_class (w_class)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_disp      = 1'b0;
    w_code      = 1'b0;
    unique case (w_class)
      INVALID: w_code = 1'b1;
      POS: begin
        if (r_state == RD_POS) w_disp = 1'b1;
        else                   w_state_nxt = RD_POS;
      end
      NEG: begin
        if (r_state == RD_NEG) w_disp = 1'b1;
        else                   w_state_nxt = RD_NEG;
      end
      default: ;
    endcase
    // Undefined encoding falls back to acquisition.
    if (r_state != RD_UNK && r_state != RD_NEG && r_state != RD_POS) w_state_nxt = RD_UNK;
  end

  always_comb begin
    w_lock_nxt = r_lock_cnt;
    if (w_disp || w_code || w_state_nxt == RD_UNK) w_lock_nxt = 4'd0;
    else if (r_lock_cnt < LockMax)                 w_lock_nxt = r_lock_cnt + 4'd1;
  end

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RD_UNK;
      r_lock_cnt  <= 4'd0;
      Data_10_out <= 10'd0;
      valid_out   <= 1'b0;
      RD_out      <= 1'b0;
      disp_err    <= 1'b0;
      code_err    <= 1'b0;
      rd_locked   <= 1'b0;
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_nxt;
      Data_10_out <= Data_10;
      valid_out   <= 1'b1;
      RD_out      <= (w_state_nxt == RD_POS);
      disp_err    <= w_disp;
      code_err    <= w_code;
      rd_locked   <= (w_lock_nxt == LockMax);
    end else begin
      valid_out   <= 1'b0;
      disp_err    <= 1'b0;
      code_err    <= 1'b0;
    end
  end

`ifdef RD_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  localparam logic [ERR_CNT_W-1:0] ErrOne = 1;

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      r_err_cnt <= '0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (enable && (w_disp || w_code) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ErrOne;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_rx_rd_checker.sv
// Scoreboard bench for rx_rd_checker: directed symbols with hand-computed expectations.
module tb_rx_rd_checker;

  localparam logic [9:0] SymP    = 10'b0011111010;  // 6 ones
  localparam logic [9:0] SymN    = 10'b1100000101;  // 4 ones
  localparam logic [9:0] SymZ    = 10'b1010101010;  // 5 ones
  localparam logic [9:0] SymBad7 = 10'b1111111000;  // 7 ones
  localparam logic [9:0] SymBad0 = 10'b0000000000;

  typedef struct {
    logic [9:0] data;
    logic       rd;
    logic       de;
    logic       ce;
    logic       lk;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [9:0] data_in;
  logic       clr;
  logic [9:0] data_out;
  logic       valid_out, rd_out, disp_err, code_err, rd_locked;
  logic [7:0] err_cnt;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

`ifdef RD_ERR_CNT_EN
  rx_rd_checker #(.LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .Bit_Rate_10 (clk),
    .Rst         (rst_n),
    .enable      (enable),
    .Data_10     (data_in),
    .err_cnt_clr (clr),
    .err_cnt     (err_cnt),
    .Data_10_out (data_out),
    .valid_out   (valid_out),
    .RD_out      (rd_out),
    .disp_err    (disp_err),
    .code_err    (code_err),
    .rd_locked   (rd_locked)
  );
`else
  assign err_cnt = 8'd0;
  rx_rd_checker #(.LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .Bit_Rate_10 (clk),
    .Rst         (rst_n),
    .enable      (enable),
    .Data_10     (data_in),
    .Data_10_out (data_out),
    .valid_out   (valid_out),
    .RD_out      (rd_out),
    .disp_err    (disp_err),
    .code_err    (code_err),
    .rd_locked   (rd_locked)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid output pops one expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("disp_err", 32'(disp_err), 32'(e.de));
        chk("code_err", 32'(code_err), 32'(e.ce));
        chk("rd_locked", 32'(rd_locked), 32'(e.lk));
`ifdef RD_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(e.ec));
`endif
      end
    end
  end

  task automatic send(input logic [9:0] d, input logic rd, input logic de, input logic ce,
                      input logic lk, input logic [7:0] ec, input logic c);
    exp_t e;
    @(posedge clk);
    #1;
    enable  = 1'b1;
    data_in = d;
    clr     = c;
    e.data = d; e.rd = rd; e.de = de; e.ce = ce; e.lk = lk; e.ec = ec;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic rd, input logic [9:0] d, input logic lk);
    repeat (n) begin
      @(posedge clk);
      #1;
      enable = 1'b0;
      clr    = 1'b0;
    end
    @(posedge clk);
    #2;
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_disp", 32'(disp_err), 32'd0);
    chk("idle_code", 32'(code_err), 32'd0);
    chk("idle_rd_hold", 32'(rd_out), 32'(rd));
    chk("idle_data_hold", 32'(data_out), 32'(d));
    chk("idle_lock_hold", 32'(rd_locked), 32'(lk));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_rd"}, 32'(rd_out), 32'd0);
    chk({tag, "_disp"}, 32'(disp_err), 32'd0);
    chk({tag, "_code"}, 32'(code_err), 32'd0);
    chk({tag, "_lock"}, 32'(rd_locked), 32'd0);
`ifdef RD_ERR_CNT_EN
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    data_in = 10'd0;
    clr     = 1'b0;
    #22;
    chk_reset("reset");
    rst_n = 1'b1;

    // Acquisition and lock: args are data, rd, disp, code, lock, err_cnt, clr.
    send(SymP,    1, 0, 0, 0, 8'd0, 0);
    send(SymN,    0, 0, 0, 0, 8'd0, 0);
    send(SymP,    1, 0, 0, 0, 8'd0, 0);
    send(SymN,    0, 0, 0, 1, 8'd0, 0);
    send(SymP,    1, 0, 0, 1, 8'd0, 0);
    send(SymN,    0, 0, 0, 1, 8'd0, 0);
    send(SymP,    1, 0, 0, 1, 8'd0, 0);
    // Errors drop lock; RD holds across code errors and neutral symbols.
    send(SymP,    1, 1, 0, 0, 8'd1, 0);
    send(SymBad7, 1, 0, 1, 0, 8'd2, 0);
    send(SymZ,    1, 0, 0, 0, 8'd2, 0);
    idle(3, 1'b1, SymZ, 1'b0);
    send(SymN,    0, 0, 0, 0, 8'd2, 0);
    send(SymBad0, 0, 0, 1, 0, 8'd3, 0);
    send(SymP,    1, 0, 0, 0, 8'd3, 0);
    idle(1, 1'b1, SymP, 1'b0);

    // Asynchronous reset between edges.
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    rst_n = 1'b1;

    // Back in RD_UNK: neutral and invalid do not acquire, first NEG is no disp error.
    send(SymZ,    0, 0, 0, 0, 8'd0, 0);
    send(SymBad7, 0, 0, 1, 0, 8'd1, 0);
    send(SymN,    0, 0, 0, 0, 8'd1, 0);
    send(SymN,    0, 1, 0, 0, 8'd2, 0);
    send(SymP,    1, 0, 0, 0, 8'd2, 0);
    send(SymN,    0, 0, 0, 0, 8'd2, 0);
    send(SymP,    1, 0, 0, 0, 8'd2, 0);
    send(SymN,    0, 0, 0, 1, 8'd2, 0);

`ifdef RD_ERR_CNT_EN
    begin
      logic [7:0] ec;
      ec = 8'd2;
      for (int i = 0; i < 300; i++) begin
        ec = (ec == 8'hff) ? 8'hff : ec + 8'd1;
        send(SymN, 0, 1, 0, 0, ec, 0);
      end
      send(SymN, 0, 1, 0, 0, 8'd0, 1);
      send(SymN, 0, 1, 0, 0, 8'd1, 0);
    end
`endif

    @(posedge clk);
    #1;
    enable = 1'b0;
    clr    = 1'b0;
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_rd_checker.md
Name: rx_rd_checker

Overview:
Receive-side running-disparity (RD) tracker for the 10b symbol stream. Sits after the deserializer/symbol aligner and before the 10b/8b decoder. Classifies each 10-bit symbol by ones-count, tracks RD across symbols, and flags disparity and code errors. Reports RD lock status and, optionally, a saturating error count.

Parameters:
LOCK_CNT, 4, consecutive error-free valid symbols required, after RD acquisition, to assert rd_locked (1..15)
ERR_CNT_W, 8, width of err_cnt (only used with RD_ERR_CNT_EN)

Ports:
Bit_Rate_10  in   1          symbol-rate clock; all logic on posedge
Rst          in   1          asynchronous, active-low reset
enable       in   1          Data_10 holds a valid aligned symbol this cycle
Data_10      in   10         received 10b symbol
Data_10_out  out  10         registered copy of the accepted symbol
valid_out    out  1          Data_10_out and the flags below are valid
RD_out       out  1          RD after the accepted symbol (0 = RD-, 1 = RD+)
disp_err     out  1          disparity error on the accepted symbol
code_err     out  1          ones-count outside 4..6
rd_locked    out  1          RD acquired and LOCK_CNT clean symbols seen
err_cnt_clr  in   1          (RD_ERR_CNT_EN only) synchronous clear of err_cnt
err_cnt      out  ERR_CNT_W  (RD_ERR_CNT_EN only) saturating error count

Behaviour:
- Reset (Rst=0, async): state=RD_UNK; lock counter=0; Data_10_out=0; valid_out=0; RD_out=0; disp_err=0; code_err=0; rd_locked=0; err_cnt=0.
- Symbol class from ones-count n: n=5 NEUTRAL; n=6 POS; n=4 NEG; any other n INVALID.
- Processing occurs only on clock edges with enable=1. Outputs are registered, with 1-cycle latency from the accepting edge.
- enable=0: state, lock counter and Data_10_out hold; valid_out=0, disp_err=0, code_err=0; RD_out holds.
- FSM states: RD_UNK, RD_NEG, RD_POS.
  - RD_UNK: NEUTRAL stays RD_UNK; POS goes to RD_POS; NEG goes to RD_NEG; INVALID stays RD_UNK with code_err=1. The UNK state never raises disp_err.
  - RD_NEG: NEUTRAL stays; POS goes to RD_POS; NEG gives disp_err=1 and stays RD_NEG (resync to the symbol); INVALID gives code_err=1 and stays.
  - RD_POS: NEUTRAL stays; NEG goes to RD_NEG; POS gives disp_err=1 and stays RD_POS; INVALID gives code_err=1 and stays.
- RD_out = 1 only in RD_POS after the update. In RD_UNK, RD_out=0.
- disp_err and code_err are mutually exclusive.
- Lock counter:
  - Cleared on any error and while in RD_UNK.
  - Increments on each accepted error-free symbol when the post-update state is not RD_UNK.
  - Saturates at LOCK_CNT.
  - rd_locked = (counter == LOCK_CNT), registered alongside the other flags.
- Sub-block (6b/4b) disparity is not checked; the 10b decoder owns that.

Optional Feature:
Macro RD_ERR_CNT_EN.
- Defined: the err_cnt_clr and err_cnt ports exist.
  - err_cnt increments by 1 on each cycle where disp_err or code_err is raised, and saturates at all-ones.
  - err_cnt_clr=1 forces err_cnt to 0 on the next edge; clear wins over a simultaneous error.
  - err_cnt updates in the same cycle as the flags.
- Not defined: the ports are absent and no counter logic is present; all other behaviour is identical.

Decomposition:
- Shared package rd_pkg:
  - state encoding: RD_UNK=2'b00, RD_NEG=2'b01, RD_POS=2'b10
  - symbol class encoding: NEUTRAL, POS, NEG, INVALID
  - ONES_NEG=4, ONES_NEUTRAL=5, ONES_POS=6
- One combinational sub-module, rd_sym_class: 10-bit popcount to symbol class. Reusable by the decoder.

Test Plan:
- Release reset, enable=1, Data_10=10'b0011111010 (K28.5 RD-) → next cycle valid_out=1, RD_out=1, no errors, rd_locked=0.
- Alternate 10'b1100000101 / 10'b0011111010 for 6 symbols after acquisition → no errors; rd_locked=1 from the 4th clean symbol's output cycle (LOCK_CNT=4).
- From RD_POS, send 10'b0011111010 → disp_err=1, RD_out=1, rd_locked=0; err_cnt=1 if RD_ERR_CNT_EN.
- Send 10'b1111111000 (7 ones) → code_err=1, disp_err=0, RD_out unchanged, lock counter cleared; 10'b1010101010 (neutral) → no error, RD unchanged.
- enable=0 for 3 cycles mid-stream → valid_out=0, flags 0, RD_out and Data_10_out hold; pulse Rst low mid-stream → all outputs 0 immediately, state RD_UNK.
- RD_ERR_CNT_EN, ERR_CNT_W=8: 300 consecutive disparity errors → err_cnt=255 and holds; err_cnt_clr asserted with an error on the same edge → err_cnt=0.
